button_event_decoder: RTL and testbench

- Input-side counterpart to the LED drivers. Reads the OrangeCrab user button (usr_btn, active-low, pulled up) in the clk48 domain.
- Synchronises, debounces and classifies the raw input into single-cycle events: press, release, click, long-press and optional double-click.
- Sits between the button pad and application logic, e.g. LED mode selection.

---
 rtl/button_pkg.sv | 22 ++
 rtl/button_event_decoder_debounce.sv | 54 +++++
 rtl/button_event_decoder.sv | 152 +++++++++++++++
 tb/tb_button_event_decoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared state encodings, counter-width helper and 48 MHz timing defaults
// used by the button event decoder.
package button_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HELD  = 3'd1,
    ST_LONG  = 3'd2,
    ST_GAP   = 3'd3,
    ST_HELD2 = 3'd4
  } btn_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES   = 480_000;     // 10 ms
  localparam int DEFAULT_LONG_CYCLES       = 48_000_000;  // 1 s
  localparam int DEFAULT_DOUBLE_GAP_CYCLES = 14_400_000;  // 300 ms

  // Bits needed to hold the values 0..max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/button_event_decoder_debounce.sv
// Two-flop synchroniser plus debounce counter; btn_level is the accepted,
// active-high button level with matching edge pulses.
module btn_debounce
  import button_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk48,
  input  logic rst,
  input  logic usr_btn,
  output logic btn_level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic rise_next,
  output logic fall_next
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          raw;
  logic          accept;

  assign raw    = ACTIVE_LOW ? ~sync_reg[1] : sync_reg[1];
  // A new level is accepted on the edge after the count has reached the limit.
  assign accept    = (raw != btn_level) && (cnt_reg == CW'(DEBOUNCE_CYCLES));
  assign rise_next = accept && !btn_level;
  assign fall_next = accept && btn_level;

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      sync_reg   <= {2{ACTIVE_LOW}};
      cnt_reg    <= '0;
      btn_level  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[0], usr_btn};
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
      if (raw == btn_level) begin
        cnt_reg <= '0;
      end else if (accept) begin
        btn_level <= ~btn_level;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Classifies the debounced OrangeCrab button into press/release/click/long
// events; define DOUBLE_CLICK_EN to add double-click detection.
module button_event_decoder
  import button_pkg::*;
#(
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES       = DEFAULT_LONG_CYCLES,
  parameter int DOUBLE_GAP_CYCLES = DEFAULT_DOUBLE_GAP_CYCLES
) (
  input  logic clk48,
  input  logic rst,
  input  logic usr_btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic double_pulse
);

  localparam int HW = cnt_width(LONG_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 2 || DOUBLE_GAP_CYCLES < 1) begin : g_bad_params
    $error("button_event_decoder: timing parameters out of range");
  end

  logic rise_next, fall_next;

  btn_debounce #(
    .ACTIVE_LOW      (ACTIVE_LOW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk48      (clk48),
    .rst        (rst),
    .usr_btn    (usr_btn),
    .btn_level  (btn_level),
    .rise_pulse (press_pulse),
    .fall_pulse (release_pulse),
    .rise_next  (rise_next),
    .fall_next  (fall_next)
  );

  // Hold count is 0 during the press_pulse cycle because it idles at 0 while released.
  logic [HW-1:0] hold_reg;
  logic          long_hit;

  assign long_hit = (hold_reg == HW'(LONG_CYCLES - 1));

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      hold_reg <= '0;
    end else if (!btn_level) begin
      hold_reg <= '0;
    end else if (hold_reg != HW'(LONG_CYCLES)) begin
      hold_reg <= hold_reg + HW'(1);
    end
  end

  btn_state_t state_reg;
  logic       click_reg;
  logic       long_reg;

`ifdef DOUBLE_CLICK_EN
  localparam int GW = cnt_width(DOUBLE_GAP_CYCLES);

  logic [GW-1:0] gap_reg;
  logic          gap_done;
  logic          double_reg;

  assign gap_done = (gap_reg == GW'(DOUBLE_GAP_CYCLES - 1));

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      gap_reg <= '0;
    end else if (state_reg == ST_GAP) begin
      gap_reg <= gap_reg + GW'(1);
    end else begin
      gap_reg <= '0;
    end
  end

  assign double_pulse = double_reg;
`else
  assign double_pulse = 1'b0;
`endif

  // Release is checked before the long threshold so a coincident release counts as a click.
  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      click_reg  <= 1'b0;
      long_reg   <= 1'b0;
`ifdef DOUBLE_CLICK_EN
      double_reg <= 1'b0;
`endif
    end else begin
      click_reg  <= 1'b0;
      long_reg   <= 1'b0;
`ifdef DOUBLE_CLICK_EN
      double_reg <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (rise_next) state_reg <= ST_HELD;
        end
        ST_HELD: begin
          if (fall_next) begin
`ifdef DOUBLE_CLICK_EN
            state_reg <= ST_GAP;
`else
            state_reg <= ST_IDLE;
            click_reg <= 1'b1;
`endif
          end else if (long_hit) begin
            state_reg <= ST_LONG;
            long_reg  <= 1'b1;
          end
        end
        ST_LONG: begin
          if (fall_next) state_reg <= ST_IDLE;
        end
`ifdef DOUBLE_CLICK_EN
        // A press accepted on the expiry cycle still wins.
        ST_GAP: begin
          if (rise_next) begin
            state_reg <= ST_HELD2;
          end else if (gap_done) begin
            state_reg <= ST_IDLE;
            click_reg <= 1'b1;
          end
        end
        ST_HELD2: begin
          if (fall_next) begin
            state_reg  <= ST_IDLE;
            double_reg <= 1'b1;
          end else if (long_hit) begin
            state_reg <= ST_LONG;
            click_reg <= 1'b1;
            long_reg  <= 1'b1;
          end
        end
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign click_pulse = click_reg;
  assign long_pulse  = long_reg;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench: pad waveforms are turned into expected event timelines
// by an array-based model of the button rules and compared every cycle.
module tb_button_event_decoder;

  localparam int D    = 4;
  localparam int LC   = 20;
  localparam int G    = 10;
  localparam int MAXN = 512;

  logic clk48   = 1'b0;
  logic rst     = 1'b1;
  logic usr_btn = 1'b1;
  logic btn_level, press_pulse, release_pulse, click_pulse, long_pulse, double_pulse;

  int checks = 0;
  int errors = 0;
  bit dbl_en;

  bit pad_q[$];   // 1 = button pressed during that sampling edge
  int tog[$];     // edges on which the debounced level toggles
  bit e_lvl[MAXN], e_prs[MAXN], e_rel[MAXN], e_clk[MAXN], e_lng[MAXN], e_dbl[MAXN];

  always #5 clk48 = ~clk48;

  button_event_decoder #(
    .ACTIVE_LOW        (1'b1),
    .DEBOUNCE_CYCLES   (D),
    .LONG_CYCLES       (LC),
    .DOUBLE_GAP_CYCLES (G)
  ) dut (
    .clk48         (clk48),
    .rst           (rst),
    .usr_btn       (usr_btn),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .click_pulse   (click_pulse),
    .long_pulse    (long_pulse),
    .double_pulse  (double_pulse)
  );

  task automatic chk(input string tag, input int t, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   0, btn_level,     1'b0);
    chk({tag, "_press"},   0, press_pulse,   1'b0);
    chk({tag, "_release"}, 0, release_pulse, 1'b0);
    chk({tag, "_click"},   0, click_pulse,   1'b0);
    chk({tag, "_long"},    0, long_pulse,    1'b0);
    chk({tag, "_double"},  0, double_pulse,  1'b0);
  endtask

  task automatic add_seg(input bit pressed, input int n);
    for (int i = 0; i < n; i++) pad_q.push_back(pressed);
  endtask

  task automatic mark(input int kind, input int t);
    if (t < MAXN) begin
      case (kind)
        0: e_clk[t] = 1'b1;
        1: e_lng[t] = 1'b1;
        default: e_dbl[t] = 1'b1;
      endcase
    end
  endtask

  // Expected outputs straight from the rules: a level is accepted after D+1
  // consecutive samples, visible D+2 edges after the first; events follow from
  // press/release times with plain arithmetic.
  task automatic build_model(input int n);
    bit lvl, ok, has_pend, second;
    int t, p, r, pend_r;
    for (int i = 0; i < MAXN; i++) begin
      e_lvl[i] = 0; e_prs[i] = 0; e_rel[i] = 0; e_clk[i] = 0; e_lng[i] = 0; e_dbl[i] = 0;
    end
    tog.delete();
    lvl = 1'b0;
    t = 0;
    while (t + D < n) begin
      ok = (pad_q[t] != lvl);
      for (int k = 1; k <= D && ok; k++) if (pad_q[t + k] == lvl) ok = 1'b0;
      if (ok) begin
        tog.push_back(t + D + 2);
        lvl = ~lvl;
        t = t + D + 1;
      end else begin
        t++;
      end
    end
    for (int i = 0; i < tog.size(); i++) begin
      if (tog[i] < MAXN) begin
        if (i % 2 == 0) e_prs[tog[i]] = 1'b1;
        else            e_rel[tog[i]] = 1'b1;
      end
      for (int c = tog[i]; c < MAXN; c++) e_lvl[c] = (i % 2 == 0);
    end
    has_pend = 1'b0;
    pend_r = 0;
    for (int i = 0; i < tog.size(); i += 2) begin
      p = tog[i];
      r = (i + 1 < tog.size()) ? tog[i + 1] : (1 << 30);
      if (!dbl_en) begin
        if (r - p <= LC) mark(0, r);
        else             mark(1, p + LC);
      end else begin
        second = has_pend && (p - pend_r <= G);
        if (has_pend && !second) mark(0, pend_r + G);
        has_pend = 1'b0;
        if (r - p <= LC) begin
          if (second) mark(2, r);
          else begin
            has_pend = 1'b1;
            pend_r = r;
          end
        end else begin
          mark(1, p + LC);
          if (second) mark(0, p + LC);
        end
      end
    end
    if (has_pend) mark(0, pend_r + G);
  endtask

  task automatic run_scenario(input string name);
    int n, np, nc, nl, nd;
    n = pad_q.size();
    build_model(n);
    np = 0; nc = 0; nl = 0; nd = 0;
    for (int t = 0; t < n; t++) begin
      usr_btn = pad_q[t] ? 1'b0 : 1'b1;
      @(posedge clk48);
      #1;
      chk({name, "_level"},   t, btn_level,     e_lvl[t]);
      chk({name, "_press"},   t, press_pulse,   e_prs[t]);
      chk({name, "_release"}, t, release_pulse, e_rel[t]);
      chk({name, "_click"},   t, click_pulse,   e_clk[t]);
      chk({name, "_long"},    t, long_pulse,    e_lng[t]);
      chk({name, "_double"},  t, double_pulse,  e_dbl[t]);
      np += int'(e_prs[t]); nc += int'(e_clk[t]); nl += int'(e_lng[t]); nd += int'(e_dbl[t]);
    end
    $display("scenario %s: %0d cycles, presses=%0d clicks=%0d longs=%0d doubles=%0d",
             name, n, np, nc, nl, nd);
    pad_q.delete();
  endtask

  task automatic do_reset(input string tag);
    usr_btn = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk48);
    #1;
    chk_all_zero(tag);
    @(negedge clk48);
    rst = 1'b0;
  endtask

  initial begin
`ifdef DOUBLE_CLICK_EN
    dbl_en = 1'b1;
`else
    dbl_en = 1'b0;
`endif

    do_reset("reset");
    add_seg(1, 10); add_seg(0, 40);
    run_scenario("clean_press");

    do_reset("reset_b");
    for (int i = 0; i < 5; i++) begin
      add_seg(1, 2); add_seg(0, 2);
    end
    add_seg(0, 30);
    run_scenario("bounce");

    do_reset("reset_l");
    add_seg(1, 40); add_seg(0, 20);
    run_scenario("long_press");

    do_reset("reset_c");
    add_seg(1, 19); add_seg(0, 40);
    run_scenario("threshold_19");

    do_reset("reset_c2");
    add_seg(1, 21); add_seg(0, 20);
    run_scenario("threshold_21");

    do_reset("reset_d");
    add_seg(1, 8); add_seg(0, 6); add_seg(1, 8); add_seg(0, 40);
    run_scenario("double_gap6");

    do_reset("reset_d2");
    add_seg(1, 8); add_seg(0, 20); add_seg(1, 8); add_seg(0, 40);
    run_scenario("double_gap20");

    do_reset("reset_m");
    add_seg(1, 12);
    run_scenario("pre_reset_press");
    rst = 1'b1;
    #1;
    chk_all_zero("mid_press_reset");
    @(negedge clk48);
    rst = 1'b0;
    add_seg(1, 30); add_seg(0, 10);
    run_scenario("post_reset_hold");

    for (int s = 0; s < 8; s++) begin
      do_reset("reset_r");
      for (int k = 0; k < 10; k++) add_seg(k % 2 == 0, $urandom_range(1, 30));
      add_seg(0, 60);
      run_scenario($sformatf("random_%0d", s));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
